// File: rtl/ir_receiver_if.sv
// Bus-side register access port of the IR receiver.
// Latency: none of its own; it only groups the bus wires.
// Backpressure: none; the bus is a plain strobe/address bus with no stall.
//
// Signals: BUS_WE write strobe, BUS_ADDR address, BUS_DATA_IN write data
// (master -> slave); BUS_DATA_OUT read data, BUS_DATA_OE read-hit flag
// (slave -> master).
interface ir_receiver_if;
    logic       BUS_WE;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA_IN;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OE;

    modport master (
        output BUS_WE, BUS_ADDR, BUS_DATA_IN,
        input  BUS_DATA_OUT, BUS_DATA_OE
    );

    modport slave (
        input  BUS_WE, BUS_ADDR, BUS_DATA_IN,
        output BUS_DATA_OUT, BUS_DATA_OE
    );
endinterface

// File: rtl/ir_receiver.sv
// IR remote packet decoder: burst/gap length classification into a 4-bit command.
// Latency: command committed 1 CLK after the tick that classifies the last bit burst.
// Backpressure: none; CMD_VALID is sticky and a new command may overwrite an unread one.
//
// Ports: CLK, RESET (sync, active-high), IR_IN (async envelope),
// bus (slave modport: status/command at IO_ADDRESS, error counter at
// IO_ADDRESS+1), COMMAND {forward, backward, left, right}, CMD_VALID.
module ir_receiver #(
    parameter logic [7:0] IO_ADDRESS            = 8'h92,
    parameter int         IN_MHZ                = 100,
    parameter int         SM_KHZ                = 40,
    parameter int         START_BURST_SIZE      = 88,
    parameter int         CAR_SELECT_BURST_SIZE = 22,
    parameter int         GAP_SIZE              = 40,
    parameter int         ASSERT_BURST_SIZE     = 44,
    parameter int         DEASSERT_BURST_SIZE   = 22,
    parameter int         TOLERANCE             = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IR_IN,
    ir_receiver_if.slave  bus,
    output logic [3:0]    COMMAND,
    output logic          CMD_VALID
);

    localparam int             DIV       = IN_MHZ * 1000 / SM_KHZ;
    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(DIV - 1);
    localparam logic [7:0]     ERR_ADDR  = IO_ADDRESS + 8'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_CARSEL, S_BITS} state_t;

    logic          ir_meta_q, ir_meta_d, ir_sync_q, ir_sync_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          prev_q, prev_d;
    logic [7:0]    burst_len_q, burst_len_d, gap_len_q, gap_len_d;
    state_t        state_q, state_d;
    logic [1:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    shift_q, shift_d;
    logic [3:0]    command_q, command_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [7:0]    dout_q, dout_d;
    logic          oe_q, oe_d;

    logic tick, err, restart, commit, bit_val, hit_cmd, hit_err;
    logic data_in_unused;

    assign hit_cmd        = (bus.BUS_ADDR == IO_ADDRESS);
    assign hit_err        = (bus.BUS_ADDR == ERR_ADDR);
    assign data_in_unused = ^bus.BUS_DATA_IN[7:1];

    function automatic logic len_match(input logic [7:0] len, input int nominal);
        int l;
        l = int'(len);
        return (l >= nominal - TOLERANCE) && (l <= nominal + TOLERANCE);
    endfunction

    always_comb begin
        ir_meta_d   = IR_IN;
        ir_sync_d   = ir_meta_q;
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
        prev_d      = prev_q;
        burst_len_d = burst_len_q;
        gap_len_d   = gap_len_q;
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        command_d   = command_q;
        cmd_valid_d = cmd_valid_q;
        err_cnt_d   = err_cnt_q;
        err         = 1'b0;
        restart     = 1'b0;
        commit      = 1'b0;
        bit_val     = 1'b0;

        if (tick) begin
            prev_d = ir_sync_q;
            if (ir_sync_q) begin
                if (!prev_q) begin
                    // Burst starts: the gap that just ended must not be too short.
                    burst_len_d = 8'd1;
                    if (state_q != S_IDLE && int'(gap_len_q) < GAP_SIZE - TOLERANCE)
                        err = 1'b1;
                end else if (burst_len_q != 8'hFF) begin
                    burst_len_d = burst_len_q + 8'd1;
                end
            end else if (prev_q) begin
                // Falling sample: the burst just ended, classify it.
                gap_len_d = 8'd1;
                if (len_match(burst_len_q, START_BURST_SIZE)) begin
                    state_d = S_START;
                    if (state_q != S_IDLE) begin
                        err     = 1'b1;
                        restart = 1'b1;
                    end
                end else begin
                    case (state_q)
                        S_IDLE: ;
                        S_START: begin
                            if (len_match(burst_len_q, CAR_SELECT_BURST_SIZE)) begin
                                state_d   = S_CARSEL;
                                bit_idx_d = 2'd3;
                                shift_d   = '0;
                            end else begin
                                err = 1'b1;
                            end
                        end
                        default: begin
                            if (len_match(burst_len_q, ASSERT_BURST_SIZE) ||
                                len_match(burst_len_q, DEASSERT_BURST_SIZE)) begin
                                bit_val = len_match(burst_len_q, ASSERT_BURST_SIZE);
                                shift_d = {shift_q[1:0], bit_val};
                                if (bit_idx_q == 2'd0) begin
                                    commit  = 1'b1;
                                    state_d = S_IDLE;
                                end else begin
                                    bit_idx_d = bit_idx_q - 2'd1;
                                    state_d   = S_BITS;
                                end
                            end else begin
                                err = 1'b1;
                            end
                        end
                    endcase
                end
            end else begin
                if (gap_len_q != 8'hFF)
                    gap_len_d = gap_len_q + 8'd1;
                // Fires once, on the first sample that pushes the gap past the limit.
                if (state_q != S_IDLE && int'(gap_len_q) == GAP_SIZE + TOLERANCE)
                    err = 1'b1;
            end
        end

        if (err) begin
            state_d = restart ? S_START : S_IDLE;
            shift_d = '0;
            if (err_cnt_q != 8'hFF)
                err_cnt_d = err_cnt_q + 8'd1;
        end
        if (commit) begin
            command_d   = {shift_q, bit_val};
            cmd_valid_d = 1'b1;
        end

        // A clear racing a commit loses, so a fresh command is never dropped.
        if (bus.BUS_WE) begin
            if (hit_cmd && bus.BUS_DATA_IN[0] && !commit)
                cmd_valid_d = 1'b0;
            if (hit_err)
                err_cnt_d = 8'd0;
        end

        oe_d   = !bus.BUS_WE && (hit_cmd || hit_err);
        dout_d = dout_q;
        if (!bus.BUS_WE && hit_cmd)
            dout_d = {cmd_valid_q, 3'b000, command_q};
        else if (!bus.BUS_WE && hit_err)
            dout_d = err_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ir_meta_q   <= 1'b0;
            ir_sync_q   <= 1'b0;
            tick_cnt_q  <= '0;
            prev_q      <= 1'b0;
            burst_len_q <= 8'd0;
            gap_len_q   <= 8'd0;
            state_q     <= S_IDLE;
            bit_idx_q   <= 2'd0;
            shift_q     <= 3'd0;
            command_q   <= 4'd0;
            cmd_valid_q <= 1'b0;
            err_cnt_q   <= 8'd0;
            dout_q      <= 8'd0;
            oe_q        <= 1'b0;
        end else begin
            ir_meta_q   <= ir_meta_d;
            ir_sync_q   <= ir_sync_d;
            tick_cnt_q  <= tick_cnt_d;
            prev_q      <= prev_d;
            burst_len_q <= burst_len_d;
            gap_len_q   <= gap_len_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            command_q   <= command_d;
            cmd_valid_q <= cmd_valid_d;
            err_cnt_q   <= err_cnt_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    assign COMMAND          = command_q;
    assign CMD_VALID        = cmd_valid_q;
    assign bus.BUS_DATA_OUT = dout_q;
    assign bus.BUS_DATA_OE  = oe_q;

endmodule

// File: tb/tb_ir_receiver.sv
// Bench for ir_receiver: main instance at DIV=4, a second at DIV=1 for the
// error-counter saturation run (keeps the 300-error run short).
module tb_ir_receiver;
    localparam int         DIV    = 4;
    localparam logic [7:0] IO     = 8'h92;
    localparam logic [7:0] IO_ERR = 8'h93;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       IR_IN = 1'b0;
    logic       IR_IN_F = 1'b0;
    logic [3:0] COMMAND, COMMAND_F;
    logic       CMD_VALID, CMD_VALID_F;

    ir_receiver_if bus();
    ir_receiver_if bus_f();

    ir_receiver #(.IN_MHZ(1), .SM_KHZ(250)) dut (
        .CLK(CLK), .RESET(RESET), .IR_IN(IR_IN), .bus(bus),
        .COMMAND(COMMAND), .CMD_VALID(CMD_VALID));

    ir_receiver #(.IN_MHZ(1), .SM_KHZ(1000)) dut_fast (
        .CLK(CLK), .RESET(RESET), .IR_IN(IR_IN_F), .bus(bus_f),
        .COMMAND(COMMAND_F), .CMD_VALID(CMD_VALID_F));

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_q[$];
    logic       lvl_q[$];
    int         len_q[$];

    task automatic add(input logic lvl, input int len);
        lvl_q.push_back(lvl);
        len_q.push_back(len);
    endtask

    // Six bursts (start, car-select, 4 bits MSB first), each followed by a 40-tick gap;
    // bursts selected by adj_mask are lengthened by adj ticks.
    task automatic add_packet(input logic [3:0] cmd, input logic [5:0] adj_mask, input int adj);
        int b[6];
        b[0] = 88;
        b[1] = 22;
        for (int i = 0; i < 4; i++) b[2+i] = cmd[3-i] ? 44 : 22;
        for (int i = 0; i < 6; i++) begin
            add(1'b1, b[i] + (adj_mask[i] ? adj : 0));
            add(1'b0, 40);
        end
    endtask

    task automatic play(input bit fast);
        logic l;
        int   n;
        while (lvl_q.size() > 0) begin
            l = lvl_q.pop_front();
            n = len_q.pop_front();
            if (fast) IR_IN_F = l; else IR_IN = l;
            repeat (fast ? n : n * DIV) @(negedge CLK);
        end
    endtask

    task automatic bus_read(input bit fast, input logic [7:0] addr, output logic [8:0] oe_d);
        @(negedge CLK);
        if (fast) bus_f.BUS_ADDR = addr; else bus.BUS_ADDR = addr;
        @(negedge CLK);
        oe_d = fast ? {bus_f.BUS_DATA_OE, bus_f.BUS_DATA_OUT} : {bus.BUS_DATA_OE, bus.BUS_DATA_OUT};
        if (fast) bus_f.BUS_ADDR = 8'h00; else bus.BUS_ADDR = 8'h00;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bus.BUS_WE = 1'b1; bus.BUS_ADDR = addr; bus.BUS_DATA_IN = data;
        @(negedge CLK);
        bus.BUS_WE = 1'b0; bus.BUS_ADDR = 8'h00; bus.BUS_DATA_IN = 8'h00;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400 && CMD_VALID !== 1'b1; i++) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({COMMAND, CMD_VALID} !== 5'b0) $display("FAIL reset_cmd: got %b/%b expected 0000/0", COMMAND, CMD_VALID);
        else n_pass++;
        n_checks++;
        if ({bus.BUS_DATA_OE, bus.BUS_DATA_OUT} !== 9'h0) $display("FAIL reset_bus: got oe=%b dout=%h expected 0/00", bus.BUS_DATA_OE, bus.BUS_DATA_OUT);
        else n_pass++;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_nominal();
        logic [8:0] r;
        logic [3:0] e;
        exp_q.push_back(4'b1010);
        add_packet(4'b1010, 6'b0, 0);
        play(0);
        wait_valid();
        e = exp_q.pop_front();
        n_checks++;
        if (CMD_VALID !== 1'b1 || COMMAND !== e) $display("FAIL nominal_cmd: got %b valid=%b expected %b valid=1", COMMAND, CMD_VALID, e);
        else n_pass++;
        bus_read(0, IO, r);
        n_checks++;
        if (r !== {1'b1, 8'h8A}) $display("FAIL nominal_status: got %h expected 18a", r);
        else n_pass++;
        bus_read(0, IO_ERR, r);
        n_checks++;
        if (r !== 9'h100) $display("FAIL nominal_errcnt: got %h expected 100", r);
        else n_pass++;
        bus_write(IO, 8'h01);
        n_checks++;
        if (CMD_VALID !== 1'b0) $display("FAIL nominal_clear: got %b expected 0", CMD_VALID);
        else n_pass++;
    endtask

    task automatic test_tolerance();
        logic [3:0] cmd, e;
        logic [8:0] r;
        for (int k = 0; k < 2; k++) begin
            cmd = (k == 0) ? 4'b0110 : 4'b1001;
            exp_q.push_back(cmd);
            add_packet(cmd, 6'b111111, (k == 0) ? 4 : -4);
            play(0);
            wait_valid();
            e = exp_q.pop_front();
            n_checks++;
            if (CMD_VALID !== 1'b1 || COMMAND !== e) $display("FAIL tol_%0d: got %b valid=%b expected %b valid=1", k, COMMAND, CMD_VALID, e);
            else n_pass++;
            bus_write(IO, 8'h01);
        end
        // N+5 on each non-start burst in turn: one error, command untouched.
        for (int p = 1; p < 6; p++) begin
            add_packet(4'b1010, 6'(1 << p), 5);
            play(0);
            bus_read(0, IO_ERR, r);
            n_checks++;
            if (r !== 9'h101 || COMMAND !== 4'b1001 || CMD_VALID !== 1'b0)
                $display("FAIL over5_pos%0d: got err=%h cmd=%b valid=%b expected 101/1001/0", p, r, COMMAND, CMD_VALID);
            else n_pass++;
            bus_write(IO_ERR, 8'h00);
        end
    endtask

    task automatic test_gap_timeout();
        logic [8:0] r;
        logic [3:0] e;
        add(1'b1, 88); add(1'b0, 40); add(1'b1, 22); add(1'b0, 45);
        play(0);
        bus_read(0, IO_ERR, r);
        n_checks++;
        if (r !== 9'h101 || CMD_VALID !== 1'b0) $display("FAIL gap45_err: got err=%h valid=%b expected 101/0", r, CMD_VALID);
        else n_pass++;
        exp_q.push_back(4'b0101);
        add_packet(4'b0101, 6'b0, 0);
        play(0);
        wait_valid();
        e = exp_q.pop_front();
        n_checks++;
        if (CMD_VALID !== 1'b1 || COMMAND !== e) $display("FAIL gap45_next: got %b valid=%b expected %b valid=1", COMMAND, CMD_VALID, e);
        else n_pass++;
        bus_read(0, IO_ERR, r);
        n_checks++;
        if (r !== 9'h101) $display("FAIL gap45_errhold: got %h expected 101", r);
        else n_pass++;
        bus_write(IO_ERR, 8'h00);
        bus_write(IO, 8'h01);
    endtask

    task automatic test_commit_clear();
        logic       saw;
        logic [3:0] e;
        exp_q.push_back(4'b0011);
        add_packet(4'b0011, 6'b0, 0);
        void'(lvl_q.pop_back());
        void'(len_q.pop_back());
        play(0);
        // Clear write held on every cycle across the commit.
        bus.BUS_WE = 1'b1; bus.BUS_ADDR = IO; bus.BUS_DATA_IN = 8'h01;
        IR_IN = 1'b0;
        saw = 1'b0;
        repeat (40 * DIV) begin
            @(negedge CLK);
            if (CMD_VALID === 1'b1) saw = 1'b1;
        end
        bus.BUS_WE = 1'b0; bus.BUS_ADDR = 8'h00; bus.BUS_DATA_IN = 8'h00;
        n_checks++;
        if (saw !== 1'b1) $display("FAIL commit_vs_clear: got valid seen=%b expected 1", saw);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (CMD_VALID !== 1'b0 || COMMAND !== e) $display("FAIL later_clear: got %b valid=%b expected %b valid=0", COMMAND, CMD_VALID, e);
        else n_pass++;
    endtask

    task automatic test_lone_burst();
        logic [8:0] r;
        add(1'b1, 22); add(1'b0, 40);
        play(0);
        bus_read(0, IO_ERR, r);
        n_checks++;
        if (r !== 9'h100 || CMD_VALID !== 1'b0) $display("FAIL lone22: got err=%h valid=%b expected 100/0", r, CMD_VALID);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] r;
        logic [3:0] e;
        exp_q.push_back(4'b0011);
        add_packet(4'b0011, 6'b0, 0);
        play(0);
        wait_valid();
        e = exp_q.pop_front();
        bus_read(0, IO, r);
        n_checks++;
        if (r !== {1'b1, 4'b1000, e}) $display("FAIL pre_reset_status: got %h expected %h", r, {1'b1, 4'b1000, e});
        else n_pass++;
        add(1'b1, 88); add(1'b0, 40); add(1'b1, 30); add(1'b0, 40);
        add(1'b1, 88); add(1'b0, 40); add(1'b1, 22); add(1'b0, 40);
        add(1'b1, 44); add(1'b0, 40); add(1'b1, 22); add(1'b0, 20);
        play(0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({COMMAND, CMD_VALID, bus.BUS_DATA_OE, bus.BUS_DATA_OUT} !== 14'h0)
            $display("FAIL mid_reset_outs: got cmd=%b valid=%b oe=%b dout=%h expected all 0", COMMAND, CMD_VALID, bus.BUS_DATA_OE, bus.BUS_DATA_OUT);
        else n_pass++;
        bus_read(0, IO_ERR, r);
        n_checks++;
        if (r !== 9'h100) $display("FAIL mid_reset_err: got %h expected 100", r);
        else n_pass++;
        exp_q.push_back(4'b1100);
        add_packet(4'b1100, 6'b0, 0);
        play(0);
        wait_valid();
        e = exp_q.pop_front();
        n_checks++;
        if (CMD_VALID !== 1'b1 || COMMAND !== e) $display("FAIL post_reset_pkt: got %b valid=%b expected %b valid=1", COMMAND, CMD_VALID, e);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [8:0] r;
        // Start burst then a 1-tick gap: the next rising edge is a short-gap error.
        for (int i = 0; i < 10; i++) begin add(1'b1, 84); add(1'b0, 1); end
        play(1);
        bus_read(1, IO_ERR, r);
        n_checks++;
        if (r !== 9'h109) $display("FAIL sat_partial: got %h expected 109", r);
        else n_pass++;
        for (int i = 0; i < 290; i++) begin add(1'b1, 84); add(1'b0, 1); end
        add(1'b0, 50);
        play(1);
        bus_read(1, IO_ERR, r);
        n_checks++;
        if (r !== 9'h1FF) $display("FAIL sat_full: got %h expected 1ff", r);
        else n_pass++;
    endtask

    initial begin
        bus.BUS_WE = 1'b0;   bus.BUS_ADDR = 8'h00;   bus.BUS_DATA_IN = 8'h00;
        bus_f.BUS_WE = 1'b0; bus_f.BUS_ADDR = 8'h00; bus_f.BUS_DATA_IN = 8'h00;
        test_reset();
        test_nominal();
        test_tolerance();
        test_gap_timeout();
        test_commit_clear();
        test_lone_burst();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
